// File: rtl/joy_pkg.sv
// Shared definitions for the DB15 joystick transmitter.
//   - JOY_BITS_DEFAULT : default number of bits shifted per player
//   - joy_btn_e        : bit index of each button inside a player vector
//   - joy_tx_state_e   : transmitter frame states
package joy_pkg;

   localparam int unsigned JOY_BITS_DEFAULT = 12;

   // Bit positions inside a player vector, LSB first (R at bit 0, LS at bit 11).
   typedef enum logic [3:0] {
      BTN_R  = 4'd0,
      BTN_L  = 4'd1,
      BTN_DN = 4'd2,
      BTN_UP = 4'd3,
      BTN_A  = 4'd4,
      BTN_B  = 4'd5,
      BTN_C  = 4'd6,
      BTN_D  = 4'd7,
      BTN_E  = 4'd8,
      BTN_F  = 4'd9,
      BTN_S  = 4'd10,
      BTN_LS = 4'd11
   } joy_btn_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_DONE
   } joy_tx_state_e;

endpackage

// File: rtl/joy_db15_tx_if.sv
// DB15 host-side lines plus transmitter status.
//   joy_clk_in   : host shift clock (host -> transmitter)
//   joy_load_in  : host latch, active low (host -> transmitter)
//   joy_data_out : serial data, active low (transmitter -> host)
//   busy         : frame latched and not fully shifted
//   frame_done   : one-clk pulse after the last bit
//   overrun      : sticky, shift edge after the frame was exhausted
// Modports: master = host side, slave = transmitter side.
interface joy_db15_tx_if;

   logic joy_clk_in;
   logic joy_load_in;
   logic joy_data_out;
   logic busy;
   logic frame_done;
   logic overrun;

   modport master (
      output joy_clk_in,
      output joy_load_in,
      input  joy_data_out,
      input  busy,
      input  frame_done,
      input  overrun
   );

   modport slave (
      input  joy_clk_in,
      input  joy_load_in,
      output joy_data_out,
      output busy,
      output frame_done,
      output overrun
   );

endinterface

// File: rtl/joy_in_cond.sv
// Input conditioning for one asynchronous, idle-high host line:
// synchronizer, optional glitch filter and edge detector.
// Optional feature: define JOY_DB15_TX_GLITCH_FILTER_EN to accept a new
// level only after FILT_CYCLES consecutive identical synchronized samples.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   line_i  : raw asynchronous line
//   level_o : conditioned level
//   rise_o  : one-clk pulse on conditioned rising edge
//   fall_o  : one-clk pulse on conditioned falling edge
module joy_in_cond #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_CYCLES = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic line_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("joy_in_cond: SYNC_STAGES must be at least 2");
   end
   if (FILT_CYCLES < 1) begin : g_bad_filt
      $error("joy_in_cond: FILT_CYCLES must be at least 1");
   end

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_lvl;
   logic                   prev_q;

   // Lines idle high, so the chain resets to ones: no false edge after reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
      end
   end

   assign sync_lvl = sync_q[SYNC_STAGES-1];

`ifdef JOY_DB15_TX_GLITCH_FILTER_EN
   localparam int unsigned FCW = $clog2(FILT_CYCLES + 1);

   logic           filt_q;
   logic [FCW-1:0] fcnt_q;

   // Count consecutive samples that differ from the accepted level; any
   // agreeing sample restarts the count, so short pulses never get through.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         filt_q <= 1'b1;
         fcnt_q <= '0;
      end else if (sync_lvl == filt_q) begin
         fcnt_q <= '0;
      end else if (fcnt_q == FCW'(FILT_CYCLES - 1)) begin
         filt_q <= sync_lvl;
         fcnt_q <= '0;
      end else begin
         fcnt_q <= fcnt_q + FCW'(1);
      end
   end

   assign level_o = filt_q;
`else
   assign level_o = sync_lvl;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_q <= 1'b1;
      end else begin
         prev_q <= level_o;
      end
   end

   assign rise_o =  level_o & ~prev_q;
   assign fall_o = ~level_o &  prev_q;

endmodule

// File: rtl/joy_db15_tx.sv
// DB15 serial joystick responder: emulates the adapter's parallel-in /
// serial-out chain. The host latches with joy_load_in (low) and shifts with
// joy_clk_in rising edges; button state comes back active low.
// Optional feature: JOY_DB15_TX_GLITCH_FILTER_EN enables the line filter
// inside joy_in_cond (adds FILT_CYCLES of latency).
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   joy1    : player 1 buttons, 1 = pressed (bit 0 = R ... bit 11 = LS)
//   joy2    : player 2 buttons, same order
//   bus     : host lines and status (joy_db15_tx_if.slave)
module joy_db15_tx
   import joy_pkg::*;
#(
   parameter int unsigned BITS_PER_PLAYER = JOY_BITS_DEFAULT,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned FILT_CYCLES     = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [BITS_PER_PLAYER-1:0] joy1,
   input  logic [BITS_PER_PLAYER-1:0] joy2,
   joy_db15_tx_if.slave               bus
);

   localparam int unsigned FRAME_LEN = 2 * BITS_PER_PLAYER;
   localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1);

   logic load_lvl, load_rise;
   logic clk_rise;
   // Conditioner outputs this block has no use for.
   logic load_fall_unused, clk_lvl_unused, clk_fall_unused;

   joy_tx_state_e          state_q, state_d;
   logic [FRAME_LEN-1:0]   shreg_q, shreg_d;
   logic [CNT_W-1:0]       cnt_q,   cnt_d;
   logic                   data_q,  data_d;
   logic                   done_q,  done_d;
   logic                   ovr_q,   ovr_d;

   joy_in_cond #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_CYCLES (FILT_CYCLES)
   ) u_cond_clk (
      .clk     (clk),
      .reset_n (reset_n),
      .line_i  (bus.joy_clk_in),
      .level_o (clk_lvl_unused),
      .rise_o  (clk_rise),
      .fall_o  (clk_fall_unused)
   );

   joy_in_cond #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_CYCLES (FILT_CYCLES)
   ) u_cond_load (
      .clk     (clk),
      .reset_n (reset_n),
      .line_i  (bus.joy_load_in),
      .level_o (load_lvl),
      .rise_o  (load_rise),
      .fall_o  (load_fall_unused)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         shreg_q <= '1;
         cnt_q   <= '0;
         data_q  <= 1'b1;
         done_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         done_q  <= done_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      done_d  = 1'b0;
      ovr_d   = ovr_q;

      // Load low wins over everything, including a coincident shift edge.
      if (!load_lvl) begin
         state_d = ST_LOAD;
         shreg_d = ~{joy2, joy1};
         cnt_d   = '0;
         data_d  = ~joy1[0];
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               data_d = 1'b1;
            end
            ST_LOAD: begin
               if (load_rise) begin
                  state_d = ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (clk_rise) begin
                  shreg_d = {1'b1, shreg_q[FRAME_LEN-1:1]};
                  cnt_d   = cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                     data_d  = 1'b1;
                  end else begin
                     data_d  = shreg_q[1];
                  end
               end
            end
            ST_DONE: begin
               data_d = 1'b1;
               if (clk_rise) begin
                  ovr_d = 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   assign bus.joy_data_out = data_q;
   assign bus.busy         = (state_q == ST_SHIFT);
   assign bus.frame_done   = done_q;
   assign bus.overrun      = ovr_q;

endmodule

// File: tb/tb_joy_db15_tx.sv
`timescale 1ns/1ps
module tb_joy_db15_tx;
   import joy_pkg::*;

   localparam int unsigned B     = 12;
   localparam int unsigned FRAME = 2 * B;
   localparam int unsigned HALF  = 8;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [B-1:0] joy1, joy2;

   joy_db15_tx_if bus ();

   joy_db15_tx #(
      .BITS_PER_PLAYER (B),
      .SYNC_STAGES     (2),
      .FILT_CYCLES     (4)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .joy1    (joy1),
      .joy2    (joy2),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned done_cnt = 0;

   logic [FRAME-1:0] sb_q[$];

   always @(posedge clk) begin
      if (bus.frame_done === 1'b1) done_cnt <= done_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Host side of one frame: load pulse, then nedges shift clocks.
   // rx collects received buttons (data inverted back to active high);
   // tail is the AND of data seen after edges past the frame end.
   task automatic host_frame(input int unsigned nedges, input bit coincide,
                             input int unsigned glitch_at,
                             output logic [FRAME-1:0] rx, output logic tail);
      rx   = '0;
      tail = 1'b1;
      @(negedge clk);
      bus.joy_load_in = 1'b0;
      if (coincide) bus.joy_clk_in = 1'b1;
      repeat (10) @(negedge clk);
      bus.joy_load_in = 1'b1;
      repeat (HALF) @(negedge clk);
      rx[0] = ~bus.joy_data_out;
      bus.joy_clk_in = 1'b0;
      repeat (HALF) @(negedge clk);
      for (int unsigned e = 1; e <= nedges; e++) begin
         if (e == glitch_at) begin
            bus.joy_clk_in = 1'b1;
            repeat (2) @(negedge clk);
            bus.joy_clk_in = 1'b0;
            repeat (HALF) @(negedge clk);
         end
         bus.joy_clk_in = 1'b1;
         repeat (HALF) @(negedge clk);
         if (e < FRAME) rx[e] = ~bus.joy_data_out;
         else           tail  = tail & bus.joy_data_out;
         bus.joy_clk_in = 1'b0;
         repeat (HALF) @(negedge clk);
      end
   endtask

   task automatic run_frame(input logic [B-1:0] j1, input logic [B-1:0] j2,
                            input int unsigned nedges, input bit coincide,
                            input int unsigned glitch_at, input string tag);
      logic [FRAME-1:0] rx, exp;
      logic             tail;
      int unsigned      d0;
      joy1 = j1;
      joy2 = j2;
      sb_q.push_back({j2, j1});
      d0 = done_cnt;
      host_frame(nedges, coincide, glitch_at, rx, tail);
      exp = sb_q.pop_front();
      check({tag, "_frame"}, 32'(rx), 32'(exp));
      check({tag, "_tail"}, 32'(tail), 32'd1);
      check({tag, "_busy"}, 32'(bus.busy), 32'd0);
      check({tag, "_done"}, done_cnt - d0, 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [FRAME-1:0] rx;
      logic             tail;
      int unsigned      d0;

      reset_n         = 1'b0;
      joy1            = '0;
      joy2            = '0;
      bus.joy_clk_in  = 1'b0;
      bus.joy_load_in = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_data", 32'(bus.joy_data_out), 32'd1);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.frame_done), 32'd0);
      check("rst_ovr",  32'(bus.overrun), 32'd0);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      check("idle_data", 32'(bus.joy_data_out), 32'd1);

      // Single buttons at both ends of the frame.
      run_frame(B'(1) << BTN_R, '0, FRAME, 1'b0, 0, "p1_r");
      check("p1_r_ovr", 32'(bus.overrun), 32'd0);
      run_frame('0, B'(1) << BTN_LS, FRAME, 1'b0, 0, "p2_ls");

      // One edge too many sets the sticky overrun.
      run_frame(B'($urandom), B'($urandom), FRAME + 1, 1'b0, 0, "ovr");
      check("ovr_set", 32'(bus.overrun), 32'd1);
      run_frame(B'($urandom), B'($urandom), FRAME, 1'b0, 0, "ovr_next");
      check("ovr_sticky", 32'(bus.overrun), 32'd1);

      // Abort after 7 shifts, then restart with a changed snapshot.
      joy1 = 12'h5A5;
      joy2 = 12'h3C3;
      sb_q.push_back({joy2, joy1});
      d0 = done_cnt;
      host_frame(7, 1'b0, 0, rx, tail);
      begin
         logic [FRAME-1:0] exp;
         exp = sb_q.pop_front();
         check("abort_bits", 32'(rx[6:0]), 32'(exp[6:0]));
      end
      check("abort_busy", 32'(bus.busy), 32'd1);
      check("abort_nodone", done_cnt - d0, 32'd0);
      run_frame(12'hA5A, 12'h3C3, FRAME, 1'b0, 0, "restart");
      check("restart_ovr", 32'(bus.overrun), 32'd1);

      // Shift edge coincident with load low mid-frame.
      host_frame(5, 1'b0, 0, rx, tail);
      run_frame(B'($urandom), B'($urandom), FRAME, 1'b1, 0, "coincide");

`ifdef JOY_DB15_TX_GLITCH_FILTER_EN
      run_frame(B'($urandom), B'($urandom), FRAME, 1'b0, 5, "glitch");
`endif

      // Asynchronous reset mid-frame with all buttons pressed (data low).
      joy1 = '1;
      joy2 = '1;
      host_frame(5, 1'b0, 0, rx, tail);
      check("mid_data", 32'(bus.joy_data_out), 32'd0);
      check("mid_busy", 32'(bus.busy), 32'd1);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("arst_data", 32'(bus.joy_data_out), 32'd1);
      check("arst_busy", 32'(bus.busy), 32'd0);
      check("arst_done", 32'(bus.frame_done), 32'd0);
      check("arst_ovr",  32'(bus.overrun), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      d0 = done_cnt;
      for (int unsigned k = 0; k < 3; k++) begin
         bus.joy_clk_in = 1'b1;
         repeat (HALF) @(negedge clk);
         bus.joy_clk_in = 1'b0;
         repeat (HALF) @(negedge clk);
      end
      check("noload_data", 32'(bus.joy_data_out), 32'd1);
      check("noload_busy", 32'(bus.busy), 32'd0);
      check("noload_done", done_cnt - d0, 32'd0);

      // Receiver loopback over random frames.
      for (int unsigned f = 0; f < 100; f++) begin
         run_frame(B'($urandom), B'($urandom), FRAME, 1'b0, 0, "loop");
      end
      check("final_ovr", 32'(bus.overrun), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
